// File: rtl/aes_block_serdes.sv
// aes_block_serdes
//   Streaming converter between the 128-bit AES state block and a narrow
//   word stream. The pack path assembles NW = 128/WORD_W words into one
//   block. The unpack path splits one block back into NW words. Both paths
//   use valid/ready handshakes, move one word per clock and are independent.
//
// Parameters
//   WORD_W    : stream word width (8, 16, 32 or 64)
//   MSB_FIRST : 1 = first word sits in bits [127 -: WORD_W] (state byte 00 first)
//               0 = first word sits in bits [WORD_W-1:0]
//
// Ports
//   clk, rst                          : clock, asynchronous active-high reset
//   in_valid/in_ready/in_word         : pack input word stream
//   pk_valid/pk_ready/pk_block        : assembled 128-bit block output
//   pk_count                          : words currently held in the assembly register
//   ub_valid/ub_ready/ub_block        : 128-bit block to unpack
//   out_valid/out_ready/out_word      : unpacked word stream
//   flush (AES_SERDES_FLUSH_EN only)  : emit a partial block, zero padded
//
// Optional feature macro: AES_SERDES_FLUSH_EN
//   When defined, adds the flush input. When undefined, partial blocks stay
//   in the assembly register until they are completed or reset.

module aes_block_serdes #(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WORD_W-1:0]              in_word,
  output logic                           pk_valid,
  input  logic                           pk_ready,
  output logic [127:0]                   pk_block,
  output logic [$clog2(128/WORD_W):0]    pk_count,
  input  logic                           ub_valid,
  output logic                           ub_ready,
  input  logic [127:0]                   ub_block,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WORD_W-1:0]              out_word
`ifdef AES_SERDES_FLUSH_EN
  ,
  input  logic                           flush
`endif
);

  localparam int NW = 128 / WORD_W;
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  typedef enum logic {
    IDLE,
    EMIT
  } ustate_t;

  // Bit offset of word slot k inside a block; slot 0 is the first word on
  // the stream, so with MSB_FIRST it lives at the top of the block.
  function automatic int slot_base(input logic [IW-1:0] k);
    int pos;
    pos = MSB_FIRST ? (NW - 1 - int'(k)) : int'(k);
    return pos * WORD_W;
  endfunction

  // ---------------------------------------------------------------------
  // Pack path
  // ---------------------------------------------------------------------
  logic [127:0]  acc;
  logic [127:0]  merged;
  logic [IW-1:0] wi;
  logic          pk_stall;
  logic          in_fire;
  logic          load;

  assign pk_stall = pk_valid && !pk_ready;
  assign in_fire  = in_valid && in_ready;
  assign pk_count = {1'b0, wi};

`ifdef AES_SERDES_FLUSH_EN
  logic flush_fire;

  // A flush must not overwrite a block the consumer has not taken yet, so
  // both flush and new words are held off while the output is stalled.
  // A word accepted on the flush edge is included before the flush acts.
  assign in_ready   = !(pk_stall && (wi == LAST || flush));
  assign flush_fire = flush && !pk_stall && (wi != '0 || in_fire);
  assign load       = (in_fire && wi == LAST) || flush_fire;
`else
  // Only the word that would complete a block has to wait for the previous
  // block to drain; earlier words of the next block can keep flowing.
  assign in_ready = !(pk_stall && wi == LAST);
  assign load     = in_fire && wi == LAST;
`endif

  // The assembly register with the incoming word already dropped into its
  // slot; this is both the next acc and the block loaded on completion.
  always_comb begin
    merged = acc;
    if (in_fire) begin
      merged[slot_base(wi) +: WORD_W] = in_word;
    end
  end

  // Assembly register, word index and the registered block output. acc is
  // cleared whenever a block leaves so unfilled slots of a flushed block
  // read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      wi       <= '0;
      pk_valid <= 1'b0;
      pk_block <= '0;
    end else if (load) begin
      pk_block <= merged;
      pk_valid <= 1'b1;
      acc      <= '0;
      wi       <= '0;
    end else begin
      if (in_fire) begin
        acc <= merged;
        wi  <= wi + IW'(1);
      end
      if (pk_valid && pk_ready) begin
        pk_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Unpack path
  // ---------------------------------------------------------------------
  ustate_t       ustate;
  logic [127:0]  hold;
  logic [IW-1:0] ri;
  logic          ub_fire;
  logic          out_fire;

  // Accepting the next block on the same edge as the last word leaves no
  // bubble between consecutive blocks.
  assign ub_ready = (ustate == IDLE) || (ri == LAST && out_ready);
  assign ub_fire  = ub_valid && ub_ready;
  assign out_fire = out_valid && out_ready;

  // Holding register, read index and registered word output. A new block
  // always starts at slot 0; after the last word the path either reloads or
  // drops back to IDLE with out_valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ustate    <= IDLE;
      hold      <= '0;
      ri        <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (ub_fire) begin
      hold      <= ub_block;
      ri        <= '0;
      out_word  <= ub_block[slot_base(IW'(0)) +: WORD_W];
      out_valid <= 1'b1;
      ustate    <= EMIT;
    end else if (out_fire) begin
      if (ri == LAST) begin
        ustate    <= IDLE;
        out_valid <= 1'b0;
        ri        <= '0;
      end else begin
        ri       <= ri + IW'(1);
        out_word <= hold[slot_base(ri + IW'(1)) +: WORD_W];
      end
    end
  end

endmodule

// File: tb/tb_aes_block_serdes.sv
// tb_aes_block_serdes
//   Bench for aes_block_serdes. One instance runs with WORD_W=8,
//   MSB_FIRST=1 and is driven cycle by cycle; a second instance runs with
//   WORD_W=32, MSB_FIRST=0 with its unpack output looped into its own pack
//   input, so every block sent in must come back out unchanged.
//   Expected blocks and words are built from byte/word arithmetic and
//   queued; independent monitor processes pop and compare them.

module tb_aes_block_serdes;

`ifdef AES_SERDES_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // WORD_W=8, MSB_FIRST=1 instance
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_word  = '0;
  logic         pk_valid;
  logic         pk_ready = 1'b0;
  logic [127:0] pk_block;
  logic [4:0]   pk_count;
  logic         ub_valid = 1'b0;
  logic         ub_ready;
  logic [127:0] ub_block = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_word;
  logic         flush = 1'b0;

  // WORD_W=32, MSB_FIRST=0 instance in loopback
  logic         l_in_valid;
  logic         l_in_ready;
  logic [31:0]  l_in_word;
  logic         l_pk_valid;
  logic         l_pk_ready = 1'b1;
  logic [127:0] l_pk_block;
  logic [2:0]   l_pk_count;
  logic         l_ub_valid = 1'b0;
  logic         l_ub_ready;
  logic [127:0] l_ub_block = '0;
  logic         l_out_valid;
  logic         l_out_ready;
  logic [31:0]  l_out_word;

  assign l_in_valid  = l_out_valid;
  assign l_in_word   = l_out_word;
  assign l_out_ready = l_in_ready;

  aes_block_serdes #(.WORD_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .pk_valid(pk_valid), .pk_ready(pk_ready), .pk_block(pk_block), .pk_count(pk_count),
    .ub_valid(ub_valid), .ub_ready(ub_ready), .ub_block(ub_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word)
`ifdef AES_SERDES_FLUSH_EN
    , .flush(flush)
`endif
  );

  aes_block_serdes #(.WORD_W(32), .MSB_FIRST(1'b0)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .in_word(l_in_word),
    .pk_valid(l_pk_valid), .pk_ready(l_pk_ready), .pk_block(l_pk_block), .pk_count(l_pk_count),
    .ub_valid(l_ub_valid), .ub_ready(l_ub_ready), .ub_block(l_ub_block),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_word(l_out_word)
`ifdef AES_SERDES_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  // Reference model state and scoreboards
  logic [7:0]   pk_bytes[$];
  logic [127:0] exp_pk[$];
  logic [7:0]   exp_out[$];
  logic [31:0]  exp32_out[$];
  logic [127:0] exp32_pk[$];
  int           checks = 0;
  int           fails  = 0;
  int           cnt_now = 0;
  bit           in_acc = 1'b0;
  bit           ub_acc = 1'b0;

  localparam logic [127:0] BLK_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BLK_B = 128'h00102030405060708090a0b0c0d0e0f0;

  // Bytes in stream order, first byte at the top, short blocks zero padded
  function automatic logic [127:0] packBytes(input logic [7:0] q[$]);
    logic [127:0] blk;
    blk = '0;
    foreach (q[i]) blk = (blk << 8) | 128'(q[i]);
    blk = blk << (8 * (16 - q.size()));
    return blk;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then record what the
  // coming rising edge will transfer into the reference model.
  task automatic applyStimulus(input logic iv, input logic [7:0] iw, input logic pr,
                               input logic uv, input logic [127:0] ub, input logic orr,
                               input logic fl);
    @(negedge clk);
    in_valid  = iv;
    in_word   = iw;
    pk_ready  = pr;
    ub_valid  = uv;
    ub_block  = ub;
    out_ready = orr;
    flush     = fl;
    #1;
    cnt_now = pk_bytes.size();
    in_acc  = in_valid && in_ready;
    ub_acc  = ub_valid && ub_ready;
    if (!rst) begin
      if (in_acc) pk_bytes.push_back(in_word);
      if (pk_bytes.size() == 16) begin
        exp_pk.push_back(packBytes(pk_bytes));
        pk_bytes.delete();
      end else if (FLUSH_EN && flush && pk_bytes.size() > 0 && !(pk_valid && !pk_ready)) begin
        exp_pk.push_back(packBytes(pk_bytes));
        pk_bytes.delete();
      end
      if (ub_acc) begin
        for (int k = 0; k < 16; k++) exp_out.push_back(ub_block[127-8*k -: 8]);
      end
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0; pk_ready = 1'b0; ub_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    pk_bytes.delete(); exp_pk.delete(); exp_out.delete();
    cnt_now = 0;
    #1;
    checkOutput("rst_in_ready",  128'(in_ready),  128'(1));
    checkOutput("rst_pk_valid",  128'(pk_valid),  128'(0));
    checkOutput("rst_pk_block",  pk_block,        128'(0));
    checkOutput("rst_pk_count",  128'(pk_count),  128'(0));
    checkOutput("rst_ub_ready",  128'(ub_ready),  128'(1));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_out_word",  128'(out_word),  128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor for the byte instance: scoreboard pops, occupancy and the
  // rule that a held valid keeps its data stable.
  logic         prev_pk_hold = 1'b0;
  logic         prev_out_hold = 1'b0;
  logic [127:0] prev_pk_blk = '0;
  logic [7:0]   prev_out_w = '0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_pk_hold  = 1'b0;
      prev_out_hold = 1'b0;
    end else begin
      checkOutput("pk_count", 128'(pk_count), 128'(cnt_now));
      if (prev_pk_hold) begin
        checkOutput("pk_hold_valid", 128'(pk_valid), 128'(1));
        checkOutput("pk_hold_block", pk_block, prev_pk_blk);
      end
      if (prev_out_hold) begin
        checkOutput("out_hold_valid", 128'(out_valid), 128'(1));
        checkOutput("out_hold_word", 128'(out_word), 128'(prev_out_w));
      end
      if (pk_valid && pk_ready) begin
        if (exp_pk.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL pk_extra: got block %h, expected none", pk_block);
        end else checkOutput("pk_block_sb", pk_block, exp_pk.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL out_extra: got word %h, expected none", out_word);
        end else checkOutput("out_word_sb", 128'(out_word), 128'(exp_out.pop_front()));
      end
      prev_pk_hold  = pk_valid && !pk_ready;
      prev_pk_blk   = pk_block;
      prev_out_hold = out_valid && !out_ready;
      prev_out_w    = out_word;
    end
  end

  // Monitor for the loopback instance
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (l_out_valid && l_out_ready) begin
        if (exp32_out.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL w32_extra: got word %h, expected none", l_out_word);
        end else checkOutput("w32_word_sb", 128'(l_out_word), 128'(exp32_out.pop_front()));
      end
      if (l_pk_valid && l_pk_ready) begin
        if (exp32_pk.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL w32_pk_extra: got block %h, expected none", l_pk_block);
        end else checkOutput("w32_pk_sb", l_pk_block, exp32_pk.pop_front());
      end
    end
  end

  // Send nblk blocks through the loopback instance, first one fixed,
  // with random backpressure on its block output.
  task automatic run32(input int nblk);
    int sent = 0;
    int guard = 0;
    logic [127:0] blk;
    blk = 128'hffeeddccbbaa99887766554433221100;
    while (sent < nblk && guard < 2000) begin
      @(negedge clk);
      guard++;
      l_pk_ready = ($urandom_range(0, 3) != 0);
      l_ub_valid = 1'b1;
      l_ub_block = blk;
      #1;
      if (l_ub_ready) begin
        for (int k = 0; k < 4; k++) exp32_out.push_back(32'(blk >> (32 * k)));
        exp32_pk.push_back(blk);
        sent++;
        blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    if (sent < nblk) begin
      checks++; fails++;
      $display("[TB] FAIL w32_timeout: got %0d blocks accepted, expected %0d", sent, nblk);
    end
    @(negedge clk);
    l_ub_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      l_pk_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    l_pk_ready = 1'b1;
    repeat (8) @(negedge clk);
    #3;
    checkOutput("w32_words_left", 128'(exp32_out.size()), 128'(0));
    checkOutput("w32_blocks_left", 128'(exp32_pk.size()), 128'(0));
    checkOutput("w32_pk_count", 128'(l_pk_count), 128'(0));
  endtask

  initial begin
    logic         iv, uv, pr, orr, fl;
    logic [7:0]   iw;
    logic [127:0] ub;

    doReset();

    // Stream 00,11,..,ff: block appears one cycle after the last byte
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i * 17), 1'b1, 1'b0, '0, 1'b1, 1'b0);
      checkOutput($sformatf("t1_pk_valid_%0d", i), 128'(pk_valid), 128'(0));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t1_pk_valid", 128'(pk_valid), 128'(1));
    checkOutput("t1_pk_block", pk_block, 128'h00112233445566778899aabbccddeeff);
    checkOutput("t1_pk_count", 128'(pk_count), 128'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t1_pk_valid_drop", 128'(pk_valid), 128'(0));

    // Unpack A then B back to back with no bubble
    applyStimulus(1'b0, '0, 1'b1, 1'b1, BLK_A, 1'b1, 1'b0);
    checkOutput("t2_ub_ready_idle", 128'(ub_ready), 128'(1));
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1, BLK_B, 1'b1, 1'b0);
      checkOutput($sformatf("t2_ub_ready_%0d", i), 128'(ub_ready), 128'(i == 16));
      checkOutput($sformatf("t2_out_valid_%0d", i), 128'(out_valid), 128'(1));
      if (i == 1) checkOutput("t2_first_word", 128'(out_word), 128'h69);
      if (i == 16) checkOutput("t2_last_word", 128'(out_word), 128'h5a);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t2_next_valid", 128'(out_valid), 128'(1));
    checkOutput("t2_next_word", 128'(out_word), 128'h00);
    repeat (17) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t2_idle", 128'(out_valid), 128'(0));

    // Pack backpressure: 32 bytes with pk_ready low
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput($sformatf("t3_in_ready_%0d", i), 128'(in_ready), 128'(i != 31));
    end
    checkOutput("t3_block1", pk_block, 128'h000102030405060708090a0b0c0d0e0f);
    applyStimulus(1'b1, 8'd31, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t3_in_ready_release", 128'(in_ready), 128'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t3_valid_kept", 128'(pk_valid), 128'(1));
    checkOutput("t3_block2", pk_block, 128'h101112131415161718191a1b1c1d1e1f);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Reset with 7 bytes packed and the unpack path at ri=5
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 8'($urandom()), 1'b1, i == 1, BLK_A, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("t5_pre_count", 128'(pk_count), 128'(7));
    checkOutput("t5_pre_out_valid", 128'(out_valid), 128'(1));
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'($urandom()), 1'b1, 1'b0, '0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t5_block_seen", 128'(exp_pk.size()), 128'(0));

`ifdef AES_SERDES_FLUSH_EN
    // Flush a three-byte partial block
    applyStimulus(1'b1, 8'haa, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hbb, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hcc, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t6_flush_valid", 128'(pk_valid), 128'(1));
    checkOutput("t6_flush_block", pk_block, 128'haabbcc00000000000000000000000000);
    checkOutput("t6_flush_count", 128'(pk_count), 128'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t6_empty_flush", 128'(pk_valid), 128'(0));
`endif

    // Wide words, LSB-first, through the unpack->pack loop
    run32(12);

    // Randomized traffic on both paths of the byte instance
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (in_valid && !in_acc) begin
        iv = in_valid; iw = in_word;
      end else begin
        iv = ($urandom_range(0, 3) != 0); iw = 8'($urandom());
      end
      if (ub_valid && !ub_acc) begin
        uv = ub_valid; ub = ub_block;
      end else begin
        uv = ($urandom_range(0, 4) == 0);
        ub = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      pr  = ($urandom_range(0, 2) != 0);
      orr = ($urandom_range(0, 3) != 0);
      fl  = FLUSH_EN && ($urandom_range(0, 15) == 0);
      applyStimulus(iv, iw, pr, uv, ub, orr, fl);
    end
    iv = in_valid && !in_acc;
    iw = in_word;
    uv = ub_valid && !ub_acc;
    ub = ub_block;
    repeat (60) begin
      applyStimulus(iv, iw, 1'b1, uv, ub, 1'b1, 1'b0);
      if (in_acc) iv = 1'b0;
      if (ub_acc) uv = 1'b0;
    end
    checkOutput("rand_blocks_left", 128'(exp_pk.size()), 128'(0));
    checkOutput("rand_words_left", 128'(exp_out.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
